// File: rtl/sta_dtlb_pkg.sv
// Shared backend types for the store-address DTLB: address widths, paddr_t,
// the TLB entry layout and the refill FSM state encoding.
package sta_dtlb_pkg;

  localparam int unsigned VPN_W   = 27;
  localparam int unsigned PPN_W   = 28;
  localparam int unsigned PADDR_W = 40;

  typedef logic [PADDR_W-1:0] paddr_t;

  typedef struct packed {
    logic             valid;
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
    logic             w;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    RF_IDLE = 2'd0,
    RF_REQ  = 2'd1,
    RF_WAIT = 2'd2
  } refill_state_e;

  // Sv39 requires bits 63:39 to sign-extend bit 38; bare mode allows 40 bits.
  function automatic logic vaddr_illegal(input logic [63:0] vaddr, input logic sv39);
    logic ill;
    if (sv39) begin
      ill = (vaddr[63:39] != {25{vaddr[38]}});
    end else begin
      ill = (vaddr[63:40] != 24'h00_0000);
    end
    return ill;
  endfunction

endpackage

// File: rtl/sta2mmu_if.sv
// Request/response bundle between the store-address pipe (s0 request) and
// the DTLB (registered s1 result).
interface sta2mmu_if;
  import sta_dtlb_pkg::*;

  logic        s0_req;
  logic [63:0] s0_vaddr;
  logic        s1_miss;
  logic        s1_pagefault;
  logic        s1_illegaAddr;
  logic        s1_mmio;
  paddr_t      s1_paddr;

  modport s (
    input  s0_req, s0_vaddr,
    output s1_miss, s1_pagefault, s1_illegaAddr, s1_mmio, s1_paddr
  );

  modport m (
    output s0_req, s0_vaddr,
    input  s1_miss, s1_pagefault, s1_illegaAddr, s1_mmio, s1_paddr
  );

endinterface

// File: rtl/sta_dtlb_refill.sv
// Refill FSM for the DTLB: issues one page walk at a time and reports the
// result as an entry install or a fault-register load; sfence drops the walk.
module sta_dtlb_refill
  import sta_dtlb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VPN_W-1:0] start_vpn,
  input  logic             sfence,
  output logic             ptw_req_valid,
  input  logic             ptw_req_ready,
  output logic [VPN_W-1:0] ptw_req_vpn,
  input  logic             ptw_resp_valid,
  input  logic [PPN_W-1:0] ptw_resp_ppn,
  input  logic             ptw_resp_w,
  input  logic             ptw_resp_pf,
  output logic             inst_entry,
  output logic             inst_fault,
  output logic [VPN_W-1:0] inst_vpn,
  output logic [PPN_W-1:0] inst_ppn,
  output logic             inst_w
);

  refill_state_e    state_r, state_next_s;
  logic             drop_r, drop_next_s;
  logic             req_valid_r;
  logic [VPN_W-1:0] vpn_r;
  logic             accept_s;

  // Next-state, drop-flag and response-accept decode.
  always_comb begin
    state_next_s = state_r;
    drop_next_s  = drop_r;
    accept_s     = 1'b0;
    case (state_r)
      RF_IDLE: begin
        drop_next_s = 1'b0;
        if (start) begin
          state_next_s = RF_REQ;
        end else begin
          state_next_s = RF_IDLE;
        end
      end
      RF_REQ: begin
        // The handshake still completes after an sfence; only the answer is discarded.
        drop_next_s = drop_r | sfence;
        if (ptw_req_ready) begin
          state_next_s = RF_WAIT;
        end else begin
          state_next_s = RF_REQ;
        end
      end
      RF_WAIT: begin
        if (ptw_resp_valid) begin
          state_next_s = RF_IDLE;
          drop_next_s  = 1'b0;
          accept_s     = ~(drop_r | sfence);
        end else begin
          state_next_s = RF_WAIT;
          drop_next_s  = drop_r | sfence;
        end
      end
      default: begin
        state_next_s = RF_IDLE;
        drop_next_s  = 1'b0;
      end
    endcase
  end

  // FSM state, drop flag, registered request valid and latched vpn.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= RF_IDLE;
      drop_r      <= 1'b0;
      req_valid_r <= 1'b0;
      vpn_r       <= '0;
    end else begin
      state_r     <= state_next_s;
      drop_r      <= drop_next_s;
      req_valid_r <= (state_next_s == RF_REQ);
      if ((state_r == RF_IDLE) && start) begin
        vpn_r <= start_vpn;
      end
    end
  end

  assign ptw_req_valid = req_valid_r;
  assign ptw_req_vpn   = vpn_r;
  assign inst_entry    = accept_s & ~ptw_resp_pf;
  assign inst_fault    = accept_s & ptw_resp_pf;
  assign inst_vpn      = vpn_r;
  assign inst_ppn      = ptw_resp_ppn;
  assign inst_w        = ptw_resp_w;

endmodule

// File: rtl/sta_dtlb.sv
// Store-address DTLB: fully associative 4 KiB entries, s0 lookup with
// registered s1 result. Optional counters under STA_DTLB_PERF_EN.
module sta_dtlb
  import sta_dtlb_pkg::*;
#(
  parameter int unsigned ENTRIES  = 8,
  parameter paddr_t      MMIO_TOP = 40'h00_8000_0000
) (
  input  logic             clk,
  input  logic             rst,
  sta2mmu_if.s             sta,
  input  logic             translate_en,
  input  logic             sfence,
  output logic             ptw_req_valid,
  input  logic             ptw_req_ready,
  output logic [VPN_W-1:0] ptw_req_vpn,
  input  logic             ptw_resp_valid,
  input  logic [PPN_W-1:0] ptw_resp_ppn,
  input  logic             ptw_resp_w,
  input  logic             ptw_resp_pf
`ifdef STA_DTLB_PERF_EN
  ,
  output logic [31:0]      perf_hit,
  output logic [31:0]      perf_miss
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  tlb_entry_t       entries_r [ENTRIES];
  logic             fault_valid_r;
  logic [VPN_W-1:0] fault_vpn_r;
  logic [IDX_W-1:0] rr_ptr_r;

  logic [VPN_W-1:0] vpn_s;
  logic             illegal_s, hit_s, hit_w_s, fault_hit_s, start_s;
  logic [PPN_W-1:0] hit_ppn_s;
  logic             res_miss_s, res_pf_s, res_ill_s, res_mmio_s;
  paddr_t           res_paddr_s;
  logic [IDX_W-1:0] victim_s;
  logic             inst_entry_s, inst_fault_s, inst_w_s;
  logic [VPN_W-1:0] inst_vpn_s;
  logic [PPN_W-1:0] inst_ppn_s;

  assign vpn_s       = sta.s0_vaddr[38:12];
  assign illegal_s   = vaddr_illegal(sta.s0_vaddr, translate_en);
  assign fault_hit_s = fault_valid_r && (fault_vpn_r == vpn_s);

  // Associative match against the pre-install array contents.
  always_comb begin
    hit_s     = 1'b0;
    hit_ppn_s = '0;
    hit_w_s   = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (entries_r[i].valid && (entries_r[i].vpn == vpn_s)) begin
        hit_s     = 1'b1;
        hit_ppn_s = hit_ppn_s | entries_r[i].ppn;
        hit_w_s   = hit_w_s | entries_r[i].w;
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  // Result priority: illegal masks everything, a fault masks mmio.
  always_comb begin
    res_miss_s  = 1'b0;
    res_pf_s    = 1'b0;
    res_ill_s   = 1'b0;
    res_mmio_s  = 1'b0;
    res_paddr_s = '0;
    if (illegal_s) begin
      res_ill_s = 1'b1;
    end else if (translate_en) begin
      res_pf_s    = (hit_s && !hit_w_s) || fault_hit_s;
      res_miss_s  = !hit_s && !fault_hit_s;
      res_paddr_s = hit_s ? {hit_ppn_s, sta.s0_vaddr[11:0]} : '0;
      res_mmio_s  = !res_pf_s && !res_miss_s && (res_paddr_s < MMIO_TOP);
    end else begin
      res_paddr_s = sta.s0_vaddr[39:0];
      res_mmio_s  = (res_paddr_s < MMIO_TOP);
    end
  end

  assign start_s = sta.s0_req && translate_en && !illegal_s && res_miss_s;

  // Replacement victim: lowest invalid slot, otherwise the round-robin pointer.
  always_comb begin
    victim_s = rr_ptr_r;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!entries_r[i].valid) begin
        victim_s = IDX_W'(i);
      end else begin
        victim_s = victim_s;
      end
    end
  end

  sta_dtlb_refill u_refill (
    .clk            (clk),
    .rst            (rst),
    .start          (start_s),
    .start_vpn      (vpn_s),
    .sfence         (sfence),
    .ptw_req_valid  (ptw_req_valid),
    .ptw_req_ready  (ptw_req_ready),
    .ptw_req_vpn    (ptw_req_vpn),
    .ptw_resp_valid (ptw_resp_valid),
    .ptw_resp_ppn   (ptw_resp_ppn),
    .ptw_resp_w     (ptw_resp_w),
    .ptw_resp_pf    (ptw_resp_pf),
    .inst_entry     (inst_entry_s),
    .inst_fault     (inst_fault_s),
    .inst_vpn       (inst_vpn_s),
    .inst_ppn       (inst_ppn_s),
    .inst_w         (inst_w_s)
  );

  // Entry array, fault register and replacement pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_r[i] <= '0;
      end
      fault_valid_r <= 1'b0;
      fault_vpn_r   <= '0;
      rr_ptr_r      <= '0;
    end else if (sfence) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_r[i].valid <= 1'b0;
      end
      fault_valid_r <= 1'b0;
    end else if (inst_entry_s) begin
      entries_r[victim_s] <= '{valid: 1'b1, vpn: inst_vpn_s, ppn: inst_ppn_s, w: inst_w_s};
      rr_ptr_r            <= rr_ptr_r + IDX_W'(1);
      if (fault_valid_r && (fault_vpn_r == inst_vpn_s)) begin
        fault_valid_r <= 1'b0;
      end
    end else if (inst_fault_s) begin
      fault_valid_r <= 1'b1;
      fault_vpn_r   <= inst_vpn_s;
    end
  end

  // Registered s1 result; idle cycles present all-zero fields.
  always_ff @(posedge clk) begin
    if (!rst || !sta.s0_req) begin
      sta.s1_miss       <= 1'b0;
      sta.s1_pagefault  <= 1'b0;
      sta.s1_illegaAddr <= 1'b0;
      sta.s1_mmio       <= 1'b0;
      sta.s1_paddr      <= '0;
    end else begin
      sta.s1_miss       <= res_miss_s;
      sta.s1_pagefault  <= res_pf_s;
      sta.s1_illegaAddr <= res_ill_s;
      sta.s1_mmio       <= res_mmio_s;
      sta.s1_paddr      <= res_paddr_s;
    end
  end

`ifdef STA_DTLB_PERF_EN
  logic [31:0] perf_hit_r, perf_miss_r;

  // Saturating hit/miss counters over legal Sv39 lookups.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_hit_r  <= 32'd0;
      perf_miss_r <= 32'd0;
    end else if (sta.s0_req && translate_en && !illegal_s) begin
      if (hit_s && (perf_hit_r != 32'hFFFF_FFFF)) begin
        perf_hit_r <= perf_hit_r + 32'd1;
      end
      if (res_miss_s && (perf_miss_r != 32'hFFFF_FFFF)) begin
        perf_miss_r <= perf_miss_r + 32'd1;
      end
    end
  end

  assign perf_hit  = perf_hit_r;
  assign perf_miss = perf_miss_r;
`endif

endmodule

// File: tb/tb_sta_dtlb.sv
// Scoreboard bench for sta_dtlb: directed lookups push expected s1 results,
// a negedge monitor pops and compares; PTW traffic is driven and checked inline.
module tb_sta_dtlb;

  typedef struct {
    logic        miss, pf, ill, mmio, chk_pa;
    logic [39:0] pa;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        translate_en = 1'b0;
  logic        sfence = 1'b0;
  logic        ptw_req_valid, ptw_req_ready = 1'b0;
  logic [26:0] ptw_req_vpn;
  logic        ptw_resp_valid = 1'b0;
  logic [27:0] ptw_resp_ppn = 28'd0;
  logic        ptw_resp_w = 1'b0, ptw_resp_pf = 1'b0;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  logic s1_pending = 1'b0;

  sta2mmu_if sta_bus ();

  sta_dtlb dut (
    .clk            (clk),
    .rst            (rst),
    .sta            (sta_bus),
    .translate_en   (translate_en),
    .sfence         (sfence),
    .ptw_req_valid  (ptw_req_valid),
    .ptw_req_ready  (ptw_req_ready),
    .ptw_req_vpn    (ptw_req_vpn),
    .ptw_resp_valid (ptw_resp_valid),
    .ptw_resp_ppn   (ptw_resp_ppn),
    .ptw_resp_w     (ptw_resp_w),
    .ptw_resp_pf    (ptw_resp_pf)
  );

  always #5 clk = ~clk;

  // Monitor: compare a pending s1 result, or check idle cycles are all zero.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (s1_pending) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_s1: result with empty scoreboard");
        end else begin
          e = exp_q.pop_front();
          if (sta_bus.s1_miss !== e.miss || sta_bus.s1_pagefault !== e.pf ||
              sta_bus.s1_illegaAddr !== e.ill || sta_bus.s1_mmio !== e.mmio ||
              (e.chk_pa && sta_bus.s1_paddr !== e.pa)) begin
            n_err++;
            $display("FAIL %s: got miss=%0b pf=%0b ill=%0b mmio=%0b pa=%h, want miss=%0b pf=%0b ill=%0b mmio=%0b pa=%h",
                     e.name, sta_bus.s1_miss, sta_bus.s1_pagefault, sta_bus.s1_illegaAddr,
                     sta_bus.s1_mmio, sta_bus.s1_paddr, e.miss, e.pf, e.ill, e.mmio, e.pa);
          end
        end
      end else if (rst) begin
        n_vec++;
        if ({sta_bus.s1_miss, sta_bus.s1_pagefault, sta_bus.s1_illegaAddr,
             sta_bus.s1_mmio, sta_bus.s1_paddr} !== 44'd0) begin
          n_err++;
          $display("FAIL idle_zero: got s1 fields nonzero pa=%h, want all 0", sta_bus.s1_paddr);
        end
      end
      s1_pending = sta_bus.s0_req && rst;
    end
  end

  task automatic issue(input logic [63:0] va, input logic miss, input logic pf, input logic ill,
                       input logic mmio, input logic chk_pa, input logic [39:0] pa, input string nm);
    exp_t e;
    e.miss = miss; e.pf = pf; e.ill = ill; e.mmio = mmio; e.chk_pa = chk_pa; e.pa = pa; e.name = nm;
    exp_q.push_back(e);
    sta_bus.s0_req   = 1'b1;
    sta_bus.s0_vaddr = va;
    @(posedge clk); #1;
    sta_bus.s0_req   = 1'b0;
    sta_bus.s0_vaddr = 64'd0;
  endtask

  task automatic ptw_handshake(input logic [26:0] vpn, input string nm, output logic ok);
    int t = 0;
    while (!ptw_req_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    n_vec++;
    ok = ptw_req_valid;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_req: got no ptw_req_valid within 20 cycles, want a request", nm);
      return;
    end
    @(posedge clk); #1;
    n_vec++;
    if (ptw_req_valid !== 1'b1 || ptw_req_vpn !== vpn) begin
      n_err++;
      $display("FAIL %s_vpn: got valid=%0b vpn=%h, want valid=1 vpn=%h", nm, ptw_req_valid, ptw_req_vpn, vpn);
    end
    ptw_req_ready = 1'b1;
    @(posedge clk); #1;
    ptw_req_ready = 1'b0;
  endtask

  task automatic ptw_respond(input logic [27:0] ppn, input logic w, input logic pf);
    @(posedge clk); #1;
    ptw_resp_valid = 1'b1; ptw_resp_ppn = ppn; ptw_resp_w = w; ptw_resp_pf = pf;
    @(posedge clk); #1;
    ptw_resp_valid = 1'b0; ptw_resp_ppn = 28'd0; ptw_resp_w = 1'b0; ptw_resp_pf = 1'b0;
  endtask

  task automatic ptw_serve(input logic [26:0] vpn, input logic [27:0] ppn, input logic w,
                           input logic pf, input string nm);
    logic ok;
    ptw_handshake(vpn, nm, ok);
    if (ok) ptw_respond(ppn, w, pf);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({sta_bus.s1_miss, sta_bus.s1_pagefault, sta_bus.s1_illegaAddr, sta_bus.s1_mmio,
         sta_bus.s1_paddr, ptw_req_valid} !== 45'd0) begin
      n_err++;
      $display("FAIL reset_state: got s1/ptw_req_valid nonzero (req=%0b), want 0", ptw_req_valid);
    end
    rst = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic ok;
    logic seen;
    sta_bus.s0_req   = 1'b0;
    sta_bus.s0_vaddr = 64'd0;
    @(posedge clk); #1;
    reset_dut();
    @(posedge clk); #1;

    // Bare mode: identity mapping, MMIO below 0x8000_0000.
    translate_en = 1'b0;
    issue(64'h0000_0000_8000_1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 40'h00_8000_1234, "bare_dram");
    issue(64'h0000_0000_0000_1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 40'h00_0000_1000, "bare_mmio");
    issue(64'h0000_0000_8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 40'h00_8000_0000, "bare_mmio_top");
    issue(64'h0000_0100_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 40'h0, "bare_illegal");
    @(posedge clk); #1;

    // Sv39 miss, refill, replay hit.
    translate_en = 1'b1;
    issue(64'h0000_0000_1234_5678, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 40'h0, "sv39_miss");
    ptw_serve(27'h12345, 28'h80000, 1'b1, 1'b0, "refill_12345");
    issue(64'h0000_0000_1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 40'h00_8000_0678, "sv39_hit");

    // Non-canonical address: flagged, no walk started.
    issue(64'h0000_0040_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 40'h0, "sv39_illegal");
    seen = 1'b0;
    repeat (3) begin
      seen = seen | ptw_req_valid;
      @(posedge clk); #1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL illegal_no_ptw: got ptw_req_valid=1, want 0");
    end

    // Walk fault loads the fault register; a w=0 entry also faults.
    issue(64'h0000_0000_2000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 40'h0, "pf_miss");
    ptw_serve(27'h20000, 28'h0, 1'b0, 1'b1, "refill_pf");
    issue(64'h0000_0000_2000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 40'h0, "pf_reg_hit");
    issue(64'h0000_0000_3000_0abc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 40'h0, "ro_miss");
    ptw_serve(27'h30000, 28'h00100, 1'b0, 1'b0, "refill_ro");
    issue(64'h0000_0000_3000_0abc, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 40'h0, "ro_pf");

    // Translated address just below MMIO_TOP.
    issue(64'h0000_0000_4000_0123, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 40'h0, "mmio_miss");
    ptw_serve(27'h40000, 28'h7FFFF, 1'b1, 1'b0, "refill_mmio");
    issue(64'h0000_0000_4000_0123, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 40'h00_7FFF_F123, "mmio_hit");

    // Reset while waiting; a response in the first cycle after reset is ignored.
    issue(64'h0000_0000_6000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 40'h0, "rst_miss");
    ptw_handshake(27'h60000, "refill_rst", ok);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    ptw_resp_valid = 1'b1; ptw_resp_ppn = 28'h00700; ptw_resp_w = 1'b1;
    @(posedge clk); #1;
    ptw_resp_valid = 1'b0; ptw_resp_ppn = 28'd0; ptw_resp_w = 1'b0;
    issue(64'h0000_0000_6000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 40'h0, "rst_resp_dropped");
    ptw_serve(27'h60000, 28'h00700, 1'b1, 1'b0, "refill_after_rst");
    issue(64'h0000_0000_6000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 40'h00_0070_0000, "rst_replay_hit");

    // ENTRIES+1 refills from a clean pointer evict the first entry.
    reset_dut();
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      issue(64'(27'h100 + 27'(i)) << 12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 40'h0, "evict_fill_miss");
      ptw_serve(27'h100 + 27'(i), 28'h500 + 28'(i), 1'b1, 1'b0, "refill_evict");
    end
    issue(64'h0000_0000_0010_1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 40'h00_0050_1000, "evict_second_hit");
    issue(64'h0000_0000_0010_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 40'h0, "evict_first_miss");
    ptw_serve(27'h100, 28'h500, 1'b1, 1'b0, "refill_evicted");

    // sfence while waiting drops the response; the replay misses and re-walks.
    issue(64'h0000_0000_5000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 40'h0, "sf_miss");
    ptw_handshake(27'h50000, "refill_sf", ok);
    sfence = 1'b1;
    @(posedge clk); #1;
    sfence = 1'b0;
    ptw_respond(28'h00600, 1'b1, 1'b0);
    issue(64'h0000_0000_5000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 40'h0, "sf_dropped_miss");
    ptw_serve(27'h50000, 28'h00600, 1'b1, 1'b0, "refill_after_sf");
    issue(64'h0000_0000_5000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 40'h00_0060_0000, "sf_replay_hit");

    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sta_dtlb.md
STA_DTLB -- requirements
Module: sta_dtlb

Interface
REQ-001 SHALL have parameter ENTRIES, default 8, giving the number of fully-associative 4 KiB-page entries (power of two, 2..32).
REQ-002 SHALL have parameter MMIO_TOP, default 40'h8000_0000; any paddr below it is MMIO.
REQ-003 SHALL have ports clk (input, 1, clock) and rst (input, 1, reset); one clock, reset synchronous and active-low.
REQ-004 SHALL expose sta2mmu_if.s port "sta": s0_req, s0_vaddr[63:0] in; s1_miss, s1_pagefault, s1_illegaAddr, s1_mmio out, each 1 bit; s1_paddr (paddr_t, 40 bits) out.
REQ-005 SHALL have ports translate_en (input, 1, Sv39 on, else bare) and sfence (input, 1, invalidate all).
REQ-006 SHALL have ports ptw_req_valid (output, 1), ptw_req_ready (input, 1), ptw_req_vpn (output, 27).
REQ-007 SHALL have ports ptw_resp_valid (input, 1), ptw_resp_ppn (input, 28), ptw_resp_w (input, 1, writable and dirty), ptw_resp_pf (input, 1, walk fault).

Function
REQ-008 SHALL register all s1 outputs; a request at s0 in cycle N drives s1 in cycle N+1; s1 fields are 0 in any cycle after no s0_req.
REQ-009 SHALL flag s1_illegaAddr when vaddr[63:39] is not all equal to vaddr[38] (translate_en=1), or vaddr[63:40]!=0 (translate_en=0); illegaAddr masks miss, pagefault and mmio.
REQ-010 SHALL in bare mode return paddr=vaddr[39:0], never miss or pagefault, mmio per REQ-013.
REQ-011 SHALL in Sv39 mode compare vaddr[38:12] with all valid entries; hit gives paddr={ppn,vaddr[11:0]}; no hit gives s1_miss=1, paddr=0.
REQ-012 SHALL assert s1_pagefault on a hit entry with w=0, or when vpn equals the fault register (REQ-017); pagefault masks mmio.
REQ-013 SHALL assert s1_mmio when the result is non-faulting, non-missing and paddr < MMIO_TOP.
REQ-014 SHALL run the refill FSM IDLE -> REQ -> WAIT -> IDLE.
REQ-015 SHALL in IDLE, on a Sv39 miss with no illegal address, latch the vpn and enter REQ; a miss in REQ/WAIT starts no new refill.
REQ-016 SHALL in REQ hold ptw_req_valid=1 with a stable ptw_req_vpn until ptw_req_ready, then enter WAIT.
REQ-017 SHALL in WAIT, on ptw_resp_valid: if pf=0, write {vpn,ppn,w,valid} into the entry at the round-robin pointer and advance the pointer mod ENTRIES; if pf=1, load the fault register {vpn,valid} instead; then go to IDLE.
REQ-018 SHALL fill invalid entries before replacing valid ones: the lowest invalid index wins, else the round-robin pointer.
REQ-019 SHALL perform a lookup in the same cycle as an install against the pre-install contents.
REQ-020 SHALL on sfence clear all valid bits and the fault register next cycle. In REQ it SHALL complete the handshake, then drop the response. In WAIT it SHALL drop the pending response (drop flag), then return to IDLE. Concurrent lookups see pre-sfence contents.
REQ-021 SHALL clear the fault register when any install writes the same vpn.

Reset
REQ-022 SHALL on rst=0 at a clock edge clear all s1 outputs, ptw_req_valid, entry valid bits, the fault register, the drop flag and the round-robin pointer, and enter IDLE.
REQ-023 SHALL discard any PTW response arriving within the first cycle after a mid-refill reset.

Configuration
REQ-024 SHALL with STA_DTLB_PERF_EN defined add 32-bit saturating outputs perf_hit and perf_miss, counting Sv39 lookups (illegaAddr excluded), reset to 0.
REQ-025 SHALL without STA_DTLB_PERF_EN defined have neither perf_hit nor perf_miss ports nor their logic.

Structure
REQ-026 SHALL place paddr_t, the VPN/PPN widths, and the entry struct {valid,vpn,ppn,w} in the shared backend package.
REQ-027 SHALL implement the refill FSM plus PTW handshake as sub-module sta_dtlb_refill; lookup and array stay in sta_dtlb.

Verification
REQ-028 SHALL check: translate_en=0, vaddr 0x8000_1234 -> next cycle paddr 0x8000_1234, mmio=0; vaddr 0x1000 -> mmio=1.
REQ-029 SHALL check: Sv39 miss on vpn 0x12345 -> s1_miss=1, ptw_req_vpn=0x12345; resp ppn 0x80000 w=1; replay vaddr 0x12345678 -> paddr 0x8000_0678, no flags.
REQ-030 SHALL check: vaddr 0x0000_0040_0000_0000 in Sv39 -> s1_illegaAddr=1, no ptw_req_valid.
REQ-031 SHALL check: ptw_resp_pf=1 -> replay gives s1_pagefault=1, s1_miss=0; a w=0 entry hit -> s1_pagefault=1.
REQ-032 SHALL check: ENTRIES+1 distinct refills -> the first entry is evicted and its replay misses.
REQ-033 SHALL check: sfence in WAIT -> the response is dropped, the same vaddr misses again, and a new refill is issued.
